serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_arith_pkg.sv | 12 +
 rtl/full_subtractor.sv | 16 +
 rtl/serial_subtractor.sv | 134 +++++++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (subtractor, adder).
// Contents: state encoding of the serial operation controller.
package serial_arith_pkg;

  // IDLE: waiting for start; RUN: one bit per clock; DONE: one-cycle result pulse
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell, purely combinational.
// Ports:
//   a, b, bin : minuend bit, subtrahend bit, borrow-in
//   d, bout   : difference bit, borrow-out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin over WIDTH clocks, LSB first.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : begin a subtraction (accepted in IDLE or DONE)
//   a, b, bin       : minuend, subtrahend, borrow-in (latched at the start edge)
//   busy            : high while the state is RUN
//   done            : one-cycle pulse while the state is DONE
//   diff, bout      : result and borrow-out, held until the next completion
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_load;
  logic               w_step;
  logic               w_last;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_br;
  logic [CNT_W-1:0]   r_cnt;
  // Holds the WIDTH-1 bits already produced; the final bit joins them at transfer.
  logic [WIDTH-2:0]   r_sr;

  logic               w_d;
  logic               w_bout;
  logic [WIDTH-1:0]   w_res;

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_res  = {w_d, r_sr};

  // Per-bit cell works on the LSB of the shifting operand registers
  full_subtractor u_fs (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bout)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath control
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        // Start in the DONE cycle chains straight into the next operation
        if (start) begin
          w_load       = 1'b1;
          w_state_next = RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      r_a   <= '0;
      r_b   <= '0;
      r_br  <= 1'b0;
      r_cnt <= '0;
      r_sr  <= '0;
    end else begin
      busy <= (w_state_next == RUN);
      done <= (w_state_next == DONE);
      if (w_load) begin
        r_a   <= a;
        r_b   <= b;
        r_br  <= bin;
        r_cnt <= '0;
        r_sr  <= '0;
      end else if (w_step) begin
        r_a  <= r_a >> 1;
        r_b  <= r_b >> 1;
        r_br <= w_bout;
        r_sr <= w_res[WIDTH-1:1];
        if (w_last) begin
          diff <= w_res;
          bout <= w_bout;
        end else begin
          // Counter holds at WIDTH-1 on the last bit instead of wrapping
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
